// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: key indices, operator codes,
// keypad FSM states and the key-to-command decode.
package calc_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 4;

    // Key index = row*4 + col
    localparam logic [4:0] KEY_1    = 5'd0;
    localparam logic [4:0] KEY_2    = 5'd1;
    localparam logic [4:0] KEY_3    = 5'd2;
    localparam logic [4:0] KEY_ADD  = 5'd3;
    localparam logic [4:0] KEY_4    = 5'd4;
    localparam logic [4:0] KEY_5    = 5'd5;
    localparam logic [4:0] KEY_6    = 5'd6;
    localparam logic [4:0] KEY_SUB  = 5'd7;
    localparam logic [4:0] KEY_7    = 5'd8;
    localparam logic [4:0] KEY_8    = 5'd9;
    localparam logic [4:0] KEY_9    = 5'd10;
    localparam logic [4:0] KEY_MUL  = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_0    = 5'd13;
    localparam logic [4:0] KEY_EQ   = 5'd14;
    localparam logic [4:0] KEY_DIV  = 5'd15;
    localparam logic [4:0] KEY_BKSP = 5'd16;
    localparam logic [4:0] KEY_MS   = 5'd17;
    localparam logic [4:0] KEY_MR   = 5'd18;
    localparam logic [4:0] KEY_MC   = 5'd19;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        EMIT     = 2'd2,
        REL_WAIT = 2'd3
    } kd_state_e;

    typedef struct packed {
        logic       dig;
        logic [3:0] digit;
        logic       op;
        logic [1:0] op_code;
        logic       sub;
        logic       ex;
        logic       clr;
        logic       bksp;
        logic       ms;
        logic       mr;
        logic       mc;
    } key_cmd_t;

    function automatic key_cmd_t decode_key(input logic [4:0] idx);
        key_cmd_t c;
        c = '0;
        case (idx)
            KEY_0:    begin c.dig = 1'b1; c.digit = 4'd0; end
            KEY_1:    begin c.dig = 1'b1; c.digit = 4'd1; end
            KEY_2:    begin c.dig = 1'b1; c.digit = 4'd2; end
            KEY_3:    begin c.dig = 1'b1; c.digit = 4'd3; end
            KEY_4:    begin c.dig = 1'b1; c.digit = 4'd4; end
            KEY_5:    begin c.dig = 1'b1; c.digit = 4'd5; end
            KEY_6:    begin c.dig = 1'b1; c.digit = 4'd6; end
            KEY_7:    begin c.dig = 1'b1; c.digit = 4'd7; end
            KEY_8:    begin c.dig = 1'b1; c.digit = 4'd8; end
            KEY_9:    begin c.dig = 1'b1; c.digit = 4'd9; end
            KEY_ADD:  begin c.op = 1'b1; c.op_code = OP_ADD; end
            // Minus is both a binary operator and the sign-entry key downstream
            KEY_SUB:  begin c.op = 1'b1; c.op_code = OP_SUB; c.sub = 1'b1; end
            KEY_MUL:  begin c.op = 1'b1; c.op_code = OP_MUL; end
            KEY_DIV:  begin c.op = 1'b1; c.op_code = OP_DIV; end
            KEY_EQ:   c.ex   = 1'b1;
            KEY_C:    c.clr  = 1'b1;
            KEY_BKSP: c.bksp = 1'b1;
            KEY_MS:   c.ms   = 1'b1;
            KEY_MR:   c.mr   = 1'b1;
            KEY_MC:   c.mc   = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner: drives one row low per slot, synchronizes the columns and
// produces a per-frame snapshot (key count saturating at 2, last key index).
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [4:0] row_n,
    output logic       frame_end,
    output logic [1:0] key_count,
    output logic [4:0] key_idx
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]       LAST_ROW = 3'(NUM_ROWS - 1);

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       row_q, row_d;
    logic [4:0]       row_n_q, row_n_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [4:0]       acc_idx_q, acc_idx_d;
    logic             frame_end_q, frame_end_d;
    logic [1:0]       key_count_q, key_count_d;
    logic [4:0]       key_idx_q, key_idx_d;
    logic [1:0]       cnt_v;
    logic [4:0]       idx_v;

    // Slot timing, column sampling and frame snapshot
    always_comb begin
        div_d       = div_q;
        row_d       = row_q;
        row_n_d     = row_n_q;
        acc_cnt_d   = acc_cnt_q;
        acc_idx_d   = acc_idx_q;
        frame_end_d = 1'b0;
        key_count_d = key_count_q;
        key_idx_d   = key_idx_q;
        cnt_v       = acc_cnt_q;
        idx_v       = acc_idx_q;
        if (div_q == DIV_LAST) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (col_s2_q[c] == 1'b0) begin
                    if (cnt_v != 2'd2) begin
                        cnt_v = cnt_v + 2'd1;
                    end else begin
                        cnt_v = 2'd2;
                    end
                    idx_v = {row_q, 2'b00} + 5'(c);
                end else begin
                    cnt_v = cnt_v;
                end
            end
            div_d = '0;
            if (row_q == LAST_ROW) begin
                row_d       = 3'd0;
                frame_end_d = 1'b1;
                key_count_d = cnt_v;
                key_idx_d   = idx_v;
                acc_cnt_d   = 2'd0;
                acc_idx_d   = 5'd0;
            end else begin
                row_d     = row_q + 3'd1;
                acc_cnt_d = cnt_v;
                acc_idx_d = idx_v;
            end
            row_n_d = ~(5'b00001 << row_d);
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Scanner state registers and column synchronizer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            div_q       <= '0;
            row_q       <= 3'd0;
            row_n_q     <= 5'b11110;
            acc_cnt_q   <= 2'd0;
            acc_idx_q   <= 5'd0;
            frame_end_q <= 1'b0;
            key_count_q <= 2'd0;
            key_idx_q   <= 5'd0;
        end else begin
            col_s1_q    <= col_n;
            col_s2_q    <= col_s1_q;
            div_q       <= div_d;
            row_q       <= row_d;
            row_n_q     <= row_n_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_idx_q   <= acc_idx_d;
            frame_end_q <= frame_end_d;
            key_count_q <= key_count_d;
            key_idx_q   <= key_idx_d;
        end
    end

    assign row_n     = row_n_q;
    assign frame_end = frame_end_q;
    assign key_count = key_count_q;
    assign key_idx   = key_idx_q;

endmodule

// File: rtl/keypad_decoder.sv
// Keypad front end: debounce FSM with single-key rollover and one command pulse
// per press. Define BKSP_REPEAT_EN to add backspace auto-repeat while held.
module keypad_decoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV        = 8,
    parameter int DEBOUNCE_FRAMES = 4
`ifdef BKSP_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [4:0] row_n,
    output logic       dig,
    output logic [3:0] digit,
    output logic       op,
    output logic [1:0] op_code,
    output logic       sub,
    output logic       ex,
    output logic       clr,
    output logic       bksp,
    output logic       ms,
    output logic       mr,
    output logic       mc
);

    localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_FRAMES);

    logic       frame_end;
    logic [1:0] key_count;
    logic [4:0] key_idx;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scanner (
        .clock     (clock),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .frame_end (frame_end),
        .key_count (key_count),
        .key_idx   (key_idx)
    );

    kd_state_e  state_q, state_d;
    logic [7:0] deb_q, deb_d;
    logic [4:0] key_q, key_d;
    key_cmd_t   cmd_q, cmd_d;

`ifdef BKSP_REPEAT_EN
    localparam logic [7:0] RPT_DLY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPT_RATE = 8'(REPEAT_RATE);
    logic [7:0] hold_q, hold_d;
    logic [7:0] rate_q, rate_d;
`endif

    // Debounce / rollover FSM; command outputs default to zero so they pulse
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        key_d   = key_q;
        cmd_d   = '0;
`ifdef BKSP_REPEAT_EN
        hold_d  = hold_q;
        rate_d  = rate_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_end && key_count == 2'd1) begin
                    key_d = key_idx;
                    deb_d = 8'd1;
                    if (DEB_LIM == 8'd1) begin
                        state_d = EMIT;
                        cmd_d   = decode_key(key_idx);
                    end else begin
                        state_d = PRESS_DB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_DB: begin
                if (frame_end) begin
                    if (key_count == 2'd1 && key_idx == key_q) begin
                        deb_d = deb_q + 8'd1;
                        if (deb_d == DEB_LIM) begin
                            state_d = EMIT;
                            cmd_d   = decode_key(key_q);
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end else begin
                        state_d = IDLE;
                        deb_d   = 8'd0;
                    end
                end else begin
                    state_d = PRESS_DB;
                end
            end
            EMIT: begin
                state_d = REL_WAIT;
                deb_d   = 8'd0;
`ifdef BKSP_REPEAT_EN
                // The debounce frames already count towards the hold time
                hold_d  = (key_q == KEY_BKSP) ? DEB_LIM : 8'd0;
                rate_d  = 8'd0;
`endif
            end
            REL_WAIT: begin
                if (frame_end) begin
                    if (key_count == 2'd0) begin
                        deb_d = deb_q + 8'd1;
                    end else begin
                        deb_d = 8'd0;
                    end
                    if (deb_d == DEB_LIM) begin
                        state_d = IDLE;
                        deb_d   = 8'd0;
                    end else begin
                        state_d = REL_WAIT;
                    end
`ifdef BKSP_REPEAT_EN
                    if (key_q == KEY_BKSP && key_count == 2'd1 && key_idx == KEY_BKSP) begin
                        if (hold_q < RPT_DLY) begin
                            hold_d = hold_q + 8'd1;
                            if (hold_d == RPT_DLY) begin
                                cmd_d.bksp = 1'b1;
                            end else begin
                                cmd_d.bksp = 1'b0;
                            end
                        end else begin
                            rate_d = rate_q + 8'd1;
                            if (rate_d == RPT_RATE) begin
                                cmd_d.bksp = 1'b1;
                                rate_d     = 8'd0;
                            end else begin
                                cmd_d.bksp = 1'b0;
                            end
                        end
                    end else begin
                        hold_d = 8'd0;
                        rate_d = 8'd0;
                    end
`endif
                end else begin
                    state_d = REL_WAIT;
                end
            end
            default: begin
                state_d = REL_WAIT;
                deb_d   = 8'd0;
            end
        endcase
    end

    // FSM state, debounce counter, captured key and registered command outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= REL_WAIT;
            deb_q   <= 8'd0;
            key_q   <= 5'd0;
            cmd_q   <= '0;
`ifdef BKSP_REPEAT_EN
            hold_q  <= 8'd0;
            rate_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            key_q   <= key_d;
            cmd_q   <= cmd_d;
`ifdef BKSP_REPEAT_EN
            hold_q  <= hold_d;
            rate_q  <= rate_d;
`endif
        end
    end

    assign dig     = cmd_q.dig;
    assign digit   = cmd_q.digit;
    assign op      = cmd_q.op;
    assign op_code = cmd_q.op_code;
    assign sub     = cmd_q.sub;
    assign ex      = cmd_q.ex;
    assign clr     = cmd_q.clr;
    assign bksp    = cmd_q.bksp;
    assign ms      = cmd_q.ms;
    assign mr      = cmd_q.mr;
    assign mc      = cmd_q.mc;

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: keypad matrix model, per-frame reference model,
// decode table sweep, directed multi-frame sequences and random key activity.
module tb_keypad_decoder;

    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 5 * SD;
`ifdef BKSP_REPEAT_EN
    localparam int RD = 5;
    localparam int RR = 2;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col_n;
    logic [4:0] row_n;
    logic       dig, op, sub, ex, clr, bksp, ms, mr, mc;
    logic [3:0] digit;
    logic [1:0] op_code;
    logic [19:0] pressed = 20'd0;

    keypad_decoder #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DEB)
`ifdef BKSP_REPEAT_EN
        , .REPEAT_DELAY  (RD)
        , .REPEAT_RATE   (RR)
`endif
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .col_n   (col_n),
        .row_n   (row_n),
        .dig     (dig),
        .digit   (digit),
        .op      (op),
        .op_code (op_code),
        .sub     (sub),
        .ex      (ex),
        .clr     (clr),
        .bksp    (bksp),
        .ms      (ms),
        .mr      (mr),
        .mc      (mc)
    );

    always #5 clock = ~clock;

    // Passive matrix: a pressed key shorts its row to its column
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [4:0]  idx;
        logic [14:0] exp;   // {dig, digit, op, op_code, sub, ex, clr, bksp, ms, mr, mc}
        string       name;
    } vec_t;
    vec_t vt[20];

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int seq_base;

    // Reference model state
    bit armed;
    int cand, run, rel_run, pend, last_key, hold;

    // Count cycles in which any command pulse is present
    always @(negedge clock) begin
        if (dig | op | sub | ex | clr | bksp | ms | mr | mc) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string nm, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [19:0] kb(input int i);
        logic [19:0] v;
        v = 20'd0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        armed = 1'b0; rel_run = 0; run = 0; cand = -1; pend = -1; last_key = -1; hold = 0;
    endtask

    // One frame's snapshot applied to the press/release rules; pend = key to emit next frame
    task automatic model_frame(input logic [19:0] keys);
        int n, k;
        n = $countones(keys);
        k = -1;
        for (int i = 0; i < 20; i++) if (keys[i]) k = i;
        pend = -1;
        if (!armed) begin
            rel_run = (n == 0) ? rel_run + 1 : 0;
`ifdef BKSP_REPEAT_EN
            if (last_key == 16 && n == 1 && k == 16) begin
                hold++;
                if (hold == RD || (hold > RD && (hold - RD) % RR == 0)) pend = 16;
            end else begin
                hold = 0;
            end
`endif
            if (rel_run == DEB) begin armed = 1'b1; run = 0; end
        end else if (run == 0) begin
            if (n == 1) begin cand = k; run = 1; end
        end else if (n == 1 && k == cand) begin
            run++;
        end else begin
            run = 0;
        end
        if (armed && run == DEB) begin
            pend = cand; armed = 1'b0; rel_run = 0; run = 0; last_key = cand; hold = DEB;
        end
    endtask

    // Entered at the negedge of a frame's first cycle; leaves at the next frame's first cycle
    task automatic run_frame(input logic [19:0] keys);
        logic [14:0] exp_v, got_v;
        logic [4:0]  exp_row;
        pressed = keys;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clock);
            exp_row = ~(5'b00001 << (k / SD));
            exp_v   = (k == 1 && pend >= 0) ? vt[pend].exp : 15'd0;
            got_v   = {dig, digit, op, op_code, sub, ex, clr, bksp, ms, mr, mc};
            check("row_n", {10'd0, row_n}, {10'd0, exp_row});
            check("cmd", got_v, exp_v);
        end
        @(negedge clock);
        model_frame(keys);
    endtask

    task automatic hold_keys(input logic [19:0] keys, input int frames);
        for (int f = 0; f < frames; f++) run_frame(keys);
    endtask

    task automatic do_reset(input logic [19:0] keys, input int cycles);
        pressed = keys;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check("reset_row_n", {10'd0, row_n}, 15'b000000000011110);
            check("reset_cmd", {dig, digit, op, op_code, sub, ex, clr, bksp, ms, mr, mc}, 15'd0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int          sel, a, b, nf;
        logic [19:0] rk;
        int          exp_bk;

        vt[0]  = '{5'd0,  {1'b1, 4'd1, 3'b000, 7'b0000000}, "1"};
        vt[1]  = '{5'd1,  {1'b1, 4'd2, 3'b000, 7'b0000000}, "2"};
        vt[2]  = '{5'd2,  {1'b1, 4'd3, 3'b000, 7'b0000000}, "3"};
        vt[3]  = '{5'd3,  {1'b0, 4'd0, 3'b100, 7'b0000000}, "+"};
        vt[4]  = '{5'd4,  {1'b1, 4'd4, 3'b000, 7'b0000000}, "4"};
        vt[5]  = '{5'd5,  {1'b1, 4'd5, 3'b000, 7'b0000000}, "5"};
        vt[6]  = '{5'd6,  {1'b1, 4'd6, 3'b000, 7'b0000000}, "6"};
        vt[7]  = '{5'd7,  {1'b0, 4'd0, 3'b101, 7'b1000000}, "-"};
        vt[8]  = '{5'd8,  {1'b1, 4'd7, 3'b000, 7'b0000000}, "7"};
        vt[9]  = '{5'd9,  {1'b1, 4'd8, 3'b000, 7'b0000000}, "8"};
        vt[10] = '{5'd10, {1'b1, 4'd9, 3'b000, 7'b0000000}, "9"};
        vt[11] = '{5'd11, {1'b0, 4'd0, 3'b110, 7'b0000000}, "*"};
        vt[12] = '{5'd12, {1'b0, 4'd0, 3'b000, 7'b0010000}, "C"};
        vt[13] = '{5'd13, {1'b1, 4'd0, 3'b000, 7'b0000000}, "0"};
        vt[14] = '{5'd14, {1'b0, 4'd0, 3'b000, 7'b0100000}, "="};
        vt[15] = '{5'd15, {1'b0, 4'd0, 3'b111, 7'b0000000}, "/"};
        vt[16] = '{5'd16, {1'b0, 4'd0, 3'b000, 7'b0001000}, "BKSP"};
        vt[17] = '{5'd17, {1'b0, 4'd0, 3'b000, 7'b0000100}, "MS"};
        vt[18] = '{5'd18, {1'b0, 4'd0, 3'b000, 7'b0000010}, "MR"};
        vt[19] = '{5'd19, {1'b0, 4'd0, 3'b000, 7'b0000001}, "MC"};

        #1;
        do_reset(20'd0, 3);
        hold_keys(20'd0, DEB);

        // Decode table sweep
        seq_base = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            hold_keys(kb(int'(vt[i].idx)), 4);
            hold_keys(20'd0, 4);
        end
        check_int("table_pulses", pulse_cnt - seq_base, 20);

        // Long hold of 7
        seq_base = pulse_cnt;
        hold_keys(kb(8), 10);
        hold_keys(20'd0, 4);
        check_int("hold7_pulses", pulse_cnt - seq_base, 1);

        // Minus then divide
        seq_base = pulse_cnt;
        hold_keys(kb(7), 5);
        hold_keys(20'd0, 4);
        hold_keys(kb(15), 5);
        hold_keys(20'd0, 4);
        check_int("minus_div_pulses", pulse_cnt - seq_base, 2);

        // Bouncing 5
        seq_base = pulse_cnt;
        hold_keys(kb(5), 1);
        hold_keys(20'd0, 1);
        hold_keys(kb(5), 1);
        check_int("bounce_early", pulse_cnt - seq_base, 0);
        hold_keys(kb(5), 4);
        hold_keys(20'd0, 4);
        check_int("bounce_pulses", pulse_cnt - seq_base, 1);

        // Two keys, then incomplete release, then clean release
        seq_base = pulse_cnt;
        hold_keys(kb(0) | kb(10), 8);
        hold_keys(20'd0, 4);
        check_int("two_key_pulses", pulse_cnt - seq_base, 0);
        hold_keys(kb(1), 5);
        hold_keys(20'd0, 2);
        hold_keys(kb(1), 6);
        check_int("short_release_pulses", pulse_cnt - seq_base, 1);
        hold_keys(20'd0, 4);
        hold_keys(kb(1), 4);
        hold_keys(20'd0, 4);
        check_int("clean_repress_pulses", pulse_cnt - seq_base, 2);

        // MR held through reset
        seq_base = pulse_cnt;
        hold_keys(kb(18), 1);
        do_reset(kb(18), 3);
        hold_keys(kb(18), 10);
        check_int("mr_through_reset", pulse_cnt - seq_base, 0);
        hold_keys(20'd0, 3);
        hold_keys(kb(18), 4);
        hold_keys(20'd0, 4);
        check_int("mr_after_release", pulse_cnt - seq_base, 1);

        // Reset in the middle of debouncing
        seq_base = pulse_cnt;
        hold_keys(kb(18), 2);
        do_reset(20'd0, 2);
        hold_keys(20'd0, 4);
        check_int("reset_press_db", pulse_cnt - seq_base, 0);

        // Backspace held
        seq_base = pulse_cnt;
        hold_keys(kb(16), 12);
        hold_keys(20'd0, 4);
`ifdef BKSP_REPEAT_EN
        exp_bk = 5;
`else
        exp_bk = 1;
`endif
        check_int("bksp_hold_pulses", pulse_cnt - seq_base, exp_bk);

        // Random key activity against the reference model
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 3);
            a   = $urandom_range(0, 19);
            b   = (a + $urandom_range(1, 19)) % 20;
            nf  = $urandom_range(1, 6);
            rk  = 20'd0;
            if (sel == 1 || sel == 2) rk = kb(a);
            if (sel == 3) rk = kb(a) | kb(b);
            hold_keys(rk, nf);
        end
        hold_keys(20'd0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
